// File: rtl/lsu_mem_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ==========================================================================
// lsu_mem_stage : load/store sequencer in front of a big-endian data memory
// Rev 1.0
// ==========================================================================
module lsu_mem_stage #(
  parameter int ADDR_WIDTH  = 7,
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_ld,
  input  logic        req_is_st,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_base,
  input  logic [31:0] req_offset,
  input  logic [31:0] req_store_data,
  input  logic [4:0]  req_rd,
  output logic [31:0] mem_address,
  output logic [31:0] operand2,
  output logic        is_ld,
  output logic        is_st,
  output logic [2:0]  load_variant,
  output logic [2:0]  store_variant,
  input  logic [31:0] load_data,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_fault,
  output logic [31:0] wb_addr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(MEM_LATENCY - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        op_ld_q, op_ld_d;
  logic [4:0]  rd_q, rd_d;
  logic        req_ready_q, req_ready_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic [31:0] operand2_q, operand2_d;
  logic        is_ld_q, is_ld_d;
  logic        is_st_q, is_st_d;
  logic [2:0]  load_variant_q, load_variant_d;
  logic [2:0]  store_variant_q, store_variant_d;
  logic        wb_valid_q, wb_valid_d;
  logic        wb_we_q, wb_we_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        wb_fault_q, wb_fault_d;
  logic [31:0] wb_addr_q, wb_addr_d;

  logic [31:0] eff_addr;
  logic        ld_f3_ok, st_f3_ok, misaligned, out_of_range, fault;

  // funct3[1:0] encodes the access size: 00 byte, 01 half, 10 word
  always_comb begin
    eff_addr     = req_base + req_offset;
    ld_f3_ok     = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                   (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
    st_f3_ok     = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    misaligned   = ((req_funct3[1:0] == 2'b01) && eff_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (eff_addr[1:0] != 2'b00));
    out_of_range = (eff_addr >> ADDR_WIDTH) != 32'd0;
    fault        = (req_is_ld == req_is_st) || (req_is_ld && !ld_f3_ok) ||
                   (req_is_st && !st_f3_ok) || misaligned || out_of_range;
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    op_ld_d         = op_ld_q;
    rd_d            = rd_q;
    req_ready_d     = req_ready_q;
    mem_address_d   = mem_address_q;
    operand2_d      = operand2_q;
    is_ld_d         = is_ld_q;
    is_st_d         = is_st_q;
    load_variant_d  = load_variant_q;
    store_variant_d = store_variant_q;
    wb_valid_d      = wb_valid_q;
    wb_we_d         = wb_we_q;
    wb_rd_d         = wb_rd_q;
    wb_data_d       = wb_data_q;
    wb_fault_d      = wb_fault_q;
    wb_addr_d       = wb_addr_q;

    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        is_ld_d     = 1'b0;
        is_st_d     = 1'b0;
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          op_ld_d     = req_is_ld;
          rd_d        = req_rd;
          if (fault) begin
            // Faulting ops skip the memory entirely so no strobe ever rises
            state_d    = RESP;
            wb_valid_d = 1'b1;
            wb_fault_d = 1'b1;
            wb_we_d    = 1'b0;
            wb_data_d  = 32'd0;
            wb_rd_d    = req_rd;
            wb_addr_d  = eff_addr;
          end else begin
            state_d       = ISSUE;
            cnt_d         = 4'd0;
            mem_address_d = eff_addr;
            operand2_d    = req_store_data;
            is_ld_d       = req_is_ld;
            is_st_d       = req_is_st;
            if (req_is_ld) load_variant_d  = req_funct3;
            else           store_variant_d = req_funct3;
          end
        end
      end
      ISSUE: begin
        if (cnt_q == LAST_CNT) begin
          state_d    = RESP;
          is_ld_d    = 1'b0;
          is_st_d    = 1'b0;
          wb_valid_d = 1'b1;
          wb_fault_d = 1'b0;
          wb_we_d    = op_ld_q && (rd_q != 5'd0);
          wb_data_d  = op_ld_q ? load_data : 32'd0;
          wb_rd_d    = rd_q;
          wb_addr_d  = mem_address_q;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        if (wb_ready) begin
          state_d     = IDLE;
          wb_valid_d  = 1'b0;
          wb_we_d     = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      cnt_q           <= 4'd0;
      op_ld_q         <= 1'b0;
      rd_q            <= 5'd0;
      req_ready_q     <= 1'b0;
      mem_address_q   <= 32'd0;
      operand2_q      <= 32'd0;
      is_ld_q         <= 1'b0;
      is_st_q         <= 1'b0;
      load_variant_q  <= 3'd0;
      store_variant_q <= 3'd0;
      wb_valid_q      <= 1'b0;
      wb_we_q         <= 1'b0;
      wb_rd_q         <= 5'd0;
      wb_data_q       <= 32'd0;
      wb_fault_q      <= 1'b0;
      wb_addr_q       <= 32'd0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      op_ld_q         <= op_ld_d;
      rd_q            <= rd_d;
      req_ready_q     <= req_ready_d;
      mem_address_q   <= mem_address_d;
      operand2_q      <= operand2_d;
      is_ld_q         <= is_ld_d;
      is_st_q         <= is_st_d;
      load_variant_q  <= load_variant_d;
      store_variant_q <= store_variant_d;
      wb_valid_q      <= wb_valid_d;
      wb_we_q         <= wb_we_d;
      wb_rd_q         <= wb_rd_d;
      wb_data_q       <= wb_data_d;
      wb_fault_q      <= wb_fault_d;
      wb_addr_q       <= wb_addr_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign mem_address   = mem_address_q;
  assign operand2      = operand2_q;
  assign is_ld         = is_ld_q;
  assign is_st         = is_st_q;
  assign load_variant  = load_variant_q;
  assign store_variant = store_variant_q;
  assign wb_valid      = wb_valid_q;
  assign wb_we         = wb_we_q;
  assign wb_rd         = wb_rd_q;
  assign wb_data       = wb_data_q;
  assign wb_fault      = wb_fault_q;
  assign wb_addr       = wb_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_stage.sv
`default_nettype none
`timescale 1ns/1ps
// tb_lsu_mem_stage : scoreboard bench with a big-endian 128-byte memory model
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  always #5 clk = ~clk;

  // Unit with MEM_LATENCY = 1
  logic        req_valid = 1'b0, req_ready, req_is_ld = 1'b0, req_is_st = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_base = 32'd0, req_offset = 32'd0, req_store_data = 32'd0;
  logic [4:0]  req_rd = 5'd0;
  logic [31:0] mem_address, operand2, load_data, wb_data, wb_addr;
  logic        is_ld, is_st, wb_valid, wb_we, wb_fault;
  logic        wb_ready = 1'b1;
  logic [2:0]  load_variant, store_variant;
  logic [4:0]  wb_rd;

  // Unit with MEM_LATENCY = 3 (read-only use)
  logic        req_valid3 = 1'b0, req_ready3;
  logic [31:0] req_base3 = 32'd0;
  logic [4:0]  req_rd3 = 5'd0;
  logic [31:0] mem_address3, operand2_3, load_data3, wb_data3, wb_addr3;
  logic        is_ld3, is_st3, wb_valid3, wb_we3, wb_fault3;
  logic [2:0]  load_variant3, store_variant3;
  logic [4:0]  wb_rd3;

  lsu_mem_stage #(.ADDR_WIDTH(7), .MEM_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_is_ld(req_is_ld), .req_is_st(req_is_st), .req_funct3(req_funct3),
    .req_base(req_base), .req_offset(req_offset), .req_store_data(req_store_data),
    .req_rd(req_rd), .mem_address(mem_address), .operand2(operand2), .is_ld(is_ld),
    .is_st(is_st), .load_variant(load_variant), .store_variant(store_variant),
    .load_data(load_data), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_we(wb_we),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_fault(wb_fault), .wb_addr(wb_addr));

  lsu_mem_stage #(.ADDR_WIDTH(7), .MEM_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_is_ld(1'b1), .req_is_st(1'b0), .req_funct3(3'b010),
    .req_base(req_base3), .req_offset(32'd0), .req_store_data(32'd0),
    .req_rd(req_rd3), .mem_address(mem_address3), .operand2(operand2_3), .is_ld(is_ld3),
    .is_st(is_st3), .load_variant(load_variant3), .store_variant(store_variant3),
    .load_data(load_data3), .wb_valid(wb_valid3), .wb_ready(1'b1), .wb_we(wb_we3),
    .wb_rd(wb_rd3), .wb_data(wb_data3), .wb_fault(wb_fault3), .wb_addr(wb_addr3));

  // ---------------- memory model: byte i initialised to i ----------------
  logic [7:0] mem [128];
  logic [6:0] wa;
  initial for (int i = 0; i < 128; i++) mem[i] = i[7:0];

  function automatic logic [31:0] ext(input logic [2:0] f3, input logic [7:0] b0, b1, b2, b3);
    case (f3)
      3'b000:  return {{24{b0[7]}}, b0};
      3'b100:  return {24'h0, b0};
      3'b001:  return {{16{b0[7]}}, b0, b1};
      3'b101:  return {16'h0, b0, b1};
      default: return {b0, b1, b2, b3};
    endcase
  endfunction

  assign load_data  = ext(load_variant, mem[mem_address[6:0]], mem[mem_address[6:0] + 7'd1],
                          mem[mem_address[6:0] + 7'd2], mem[mem_address[6:0] + 7'd3]);
  assign load_data3 = ext(load_variant3, mem[mem_address3[6:0]], mem[mem_address3[6:0] + 7'd1],
                          mem[mem_address3[6:0] + 7'd2], mem[mem_address3[6:0] + 7'd3]);

  always @(posedge clk) begin
    if (!reset && is_st) begin
      wa = mem_address[6:0];
      case (store_variant)
        3'b000: mem[wa] = operand2[7:0];
        3'b001: begin mem[wa] = operand2[15:8]; mem[wa + 7'd1] = operand2[7:0]; end
        default: begin
          mem[wa] = operand2[31:24]; mem[wa + 7'd1] = operand2[23:16];
          mem[wa + 7'd2] = operand2[15:8]; mem[wa + 7'd3] = operand2[7:0];
        end
      endcase
    end
  end

  // ---------------- bookkeeping ----------------
  int n_cmp = 0, n_fail = 0, cyc = 0, exp_acc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic        flt;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] addr;
    int          due;
  } exp_t;
  exp_t q[$];

  // ---------------- writeback monitor ----------------
  logic        held = 1'b0;
  logic [70:0] h;
  always @(negedge clk) begin
    if (reset) begin
      held = 1'b0;
    end else if (wb_valid) begin
      if (!held) begin
        held = 1'b1;
        h = {wb_we, wb_rd, wb_fault, wb_data, wb_addr};
        if (q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL wb_unexpected: got wb_valid=1 addr=%0h, want no writeback", wb_addr);
        end else begin
          chk("wb_latency", cyc, q[0].due);
        end
      end else begin
        chk("wb_stable", {wb_we, wb_rd, wb_fault, wb_data, wb_addr}, h);
        chk("resp_req_ready", req_ready, 1'b0);
        chk("resp_strobes", {is_ld, is_st}, 2'b00);
      end
      if (wb_ready) begin
        held = 1'b0;
        if (q.size() != 0) begin
          exp_t e;
          e = q.pop_front();
          chk("wb_fault", wb_fault, e.flt);
          chk("wb_we",    wb_we,    e.we);
          chk("wb_rd",    wb_rd,    e.rd);
          chk("wb_data",  wb_data,  e.data);
          chk("wb_addr",  wb_addr,  e.addr);
        end
      end
    end
  end

  // ---------------- strobe monitor (latency-1 unit) ----------------
  int         run = 0, rises = 0;
  logic [31:0] saddr;
  always @(negedge clk) begin
    if (!reset) begin
      if (is_ld || is_st) begin
        chk("one_strobe", is_ld & is_st, 1'b0);
        if (run == 0) begin
          rises++;
          saddr = mem_address;
        end else begin
          chk("addr_held", mem_address, saddr);
        end
        run++;
      end else if (run != 0) begin
        chk("strobe_len", run, 1);
        run = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic ld, input logic st, input logic [2:0] f3,
                      input logic [31:0] base, input logic [31:0] off, input logic [31:0] sd,
                      input logic [4:0] rd, input logic flt, input logic we,
                      input logic [31:0] data, input logic [31:0] addr);
    exp_t e;
    logic acc;
    acc = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_is_ld = ld; req_is_st = st; req_funct3 = f3;
    req_base = base; req_offset = off; req_store_data = sd; req_rd = rd;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (req_ready) begin
        e.flt = flt; e.we = we; e.rd = rd; e.data = data; e.addr = addr;
        e.due = cyc + (flt ? 1 : 2);
        q.push_back(e);
        acc = 1'b1;
        break;
      end
    end
    if (!acc) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout: got req_ready=0 for 50 cycles, want 1");
    end else if (!flt) begin
      exp_acc++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 50; k++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    if (q.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL drain_timeout: got %0d pending, want 0", q.size());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, want finish before 100000ns");
    $fatal(1);
  end

  initial begin
    logic got;
    int   n3;
    logic [31:0] d3;
    logic we3;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_wb_valid",  wb_valid,  1'b0);
    chk("rst_strobes",   {is_ld, is_st}, 2'b00);
    chk("rst_mem_addr",  mem_address, 32'd0);
    chk("rst_wb_data",   wb_data, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_ready", req_ready, 1'b1);

    // lw 4 -> strobe on the next cycle, writeback on the one after
    send(1, 0, 3'b010, 32'd0, 32'd4, 32'd0, 5'd5, 0, 1, 32'h04050607, 32'd4);
    @(negedge clk);
    chk("lw_strobe", is_ld, 1'b1);
    chk("lw_variant", load_variant, 3'b010);
    chk("lw_addr", mem_address, 32'd4);
    @(negedge clk);
    chk("lw_strobe_drop", is_ld, 1'b0);
    chk("lw_wb_valid", wb_valid, 1'b1);

    // Store then loads of the stored word
    send(0, 1, 3'b010, 32'd0, 32'd8, 32'hDEADBEEF, 5'd0, 0, 0, 32'd0, 32'd8);
    send(1, 0, 3'b000, 32'd4, 32'd4, 32'd0, 5'd1, 0, 1, 32'hFFFFFFDE, 32'd8);
    send(1, 0, 3'b100, 32'd8, 32'd0, 32'd0, 5'd2, 0, 1, 32'h000000DE, 32'd8);
    send(1, 0, 3'b001, 32'd16, 32'hFFFFFFF8, 32'd0, 5'd3, 0, 1, 32'hFFFFDEAD, 32'd8);
    send(1, 0, 3'b101, 32'd10, 32'd0, 32'd0, 5'd4, 0, 1, 32'h0000BEEF, 32'd10);

    // Faults
    send(1, 0, 3'b001, 32'd5, 32'd0, 32'd0, 5'd6, 1, 0, 32'd0, 32'd5);
    send(1, 0, 3'b010, 32'd6, 32'd0, 32'd0, 5'd7, 1, 0, 32'd0, 32'd6);
    send(1, 0, 3'b000, 32'h7F, 32'd1, 32'd0, 5'd8, 1, 0, 32'd0, 32'h80);
    send(1, 0, 3'b011, 32'd0, 32'd0, 32'd0, 5'd9, 1, 0, 32'd0, 32'd0);
    send(1, 1, 3'b010, 32'd12, 32'd0, 32'h11223344, 5'd10, 1, 0, 32'd0, 32'd12);
    send(0, 1, 3'b100, 32'h14, 32'd0, 32'h55555555, 5'd0, 1, 0, 32'd0, 32'h14);

    // Backpressure
    drain();
    wb_ready = 1'b0;
    send(1, 0, 3'b010, 32'h10, 32'd0, 32'd0, 5'd7, 0, 1, 32'h10111213, 32'h10);
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (wb_valid) begin got = 1'b1; break; end
    end
    chk("bp_wb_valid_seen", got, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_req_ready", req_ready, 1'b0);
      chk("bp_strobes", {is_ld, is_st}, 2'b00);
    end
    @(posedge clk); #1;
    wb_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_ready", req_ready, 1'b1);
    chk("bp_idle_valid", wb_valid, 1'b0);

    // lw to x0: read happens, no register write
    send(1, 0, 3'b010, 32'd0, 32'd0, 32'd0, 5'd0, 0, 0, 32'h00010203, 32'd0);
    drain();

    // Latency-3 unit: strobe held exactly three cycles
    @(posedge clk); #1;
    req_valid3 = 1'b1; req_base3 = 32'h20; req_rd3 = 5'd9;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready3) begin got = 1'b1; break; end
    end
    chk("l3_accept", got, 1'b1);
    @(posedge clk); #1;
    req_valid3 = 1'b0;
    got = 1'b0; n3 = 0; d3 = 32'd0; we3 = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (is_ld3) n3++;
      if (wb_valid3) begin got = 1'b1; d3 = wb_data3; we3 = wb_we3; break; end
    end
    chk("l3_wb_seen", got, 1'b1);
    chk("l3_strobe_len", n3, 3);
    chk("l3_wb_data", d3, 32'h20212223);
    chk("l3_wb_we", we3, 1'b1);

    // Reset during the strobe of a store
    @(posedge clk); #1;
    req_valid = 1'b1; req_is_ld = 1'b0; req_is_st = 1'b1; req_funct3 = 3'b010;
    req_base = 32'h40; req_offset = 32'd0; req_store_data = 32'h55667788; req_rd = 5'd0;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready) begin got = 1'b1; break; end
    end
    chk("rst_st_accept", got, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    exp_acc++;
    @(negedge clk);
    chk("rst_st_strobe", is_st, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("rst_st_drop", is_st, 1'b0);
    chk("rst_st_wb", wb_valid, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_st_ready", req_ready, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rst_st_no_wb", wb_valid, 1'b0);
    end

    // Final memory and access-count checks
    chk("mem_word8", {mem[8], mem[9], mem[10], mem[11]}, 32'hDEADBEEF);
    chk("mem_word12", {mem[12], mem[13], mem[14], mem[15]}, 32'h0C0D0E0F);
    chk("mem_word20", {mem[20], mem[21], mem[22], mem[23]}, 32'h14151617);
    chk("mem_byte40", mem[64], 8'h40);
    chk("access_count", rises, exp_acc);
    chk("queue_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
